// File: rtl/wavepool_decode_arbiter.sv
// Round-robin wavepool-to-decode arbiter, one in-flight instruction per wavefront.
// Define ARB_PERF_CNT_EN to build the grant/stall performance counters.
module wavepool_decode_arbiter #(
  parameter int unsigned NUM_WF = 40,
  parameter int unsigned WFID_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] wf_ready,
  input  logic              decode_stall,
  input  logic              wf_release,
  input  logic [WFID_W-1:0] release_wfid,
  input  logic [NUM_WF-1:0] wf_flush,
  output logic              arb_valid,
  output logic [WFID_W-1:0] arb_wfid,
  output logic [NUM_WF-1:0] arb_grant,
  output logic [NUM_WF-1:0] inflight,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stalls
);

  logic [WFID_W-1:0] ptr;
  logic [WFID_W-1:0] ptr_nxt;
  logic [WFID_W-1:0] win;
  logic [NUM_WF-1:0] elig;
  logic [NUM_WF-1:0] win_oh;
  logic [NUM_WF-1:0] inflight_nxt;
  logic              found;
  logic              grant;

  // Two-pass search: slots at/after the pointer first, then the wrapped-around slots.
  always_comb begin
    elig   = wf_ready & ~inflight & ~wf_flush;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (!found && elig[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        win       = WFID_W'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_WF; i++) begin
      if (!found && elig[i]) begin
        found     = 1'b1;
        win       = WFID_W'(i);
        win_oh[i] = 1'b1;
      end
    end
    grant   = found && !decode_stall;
    ptr_nxt = (32'(win) == NUM_WF - 1) ? '0 : win + WFID_W'(1);
  end

  // Flush beats grant beats release; out-of-range release ids match no slot.
  always_comb begin
    inflight_nxt = inflight;
    for (int i = 0; i < NUM_WF; i++) begin
      if (wf_flush[i]) begin
        inflight_nxt[i] = 1'b0;
      end else if (grant && win_oh[i]) begin
        inflight_nxt[i] = 1'b1;
      end else if (wf_release && (release_wfid == WFID_W'(i))) begin
        inflight_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_valid <= 1'b0;
      arb_wfid  <= '0;
      arb_grant <= '0;
      inflight  <= '0;
      ptr       <= '0;
    end else begin
      arb_valid <= grant;
      arb_grant <= grant ? win_oh : '0;
      inflight  <= inflight_nxt;
      if (grant) begin
        arb_wfid <= win;
        ptr      <= ptr_nxt;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (grant) begin
        perf_grants <= perf_grants + 32'd1;
      end
      if (decode_stall && (elig != '0)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_wavepool_decode_arbiter.sv
// Directed and randomized bench for wavepool_decode_arbiter against a cycle-level model.
// Perf-counter expectations follow ARB_PERF_CNT_EN.
module tb_wavepool_decode_arbiter;
  localparam int unsigned NUM_WF = 40;
  localparam int unsigned WFID_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_WF-1:0] wf_ready;
  logic              decode_stall;
  logic              wf_release;
  logic [WFID_W-1:0] release_wfid;
  logic [NUM_WF-1:0] wf_flush;
  logic              arb_valid;
  logic [WFID_W-1:0] arb_wfid;
  logic [NUM_WF-1:0] arb_grant;
  logic [NUM_WF-1:0] inflight;
  logic [31:0]       perf_grants;
  logic [31:0]       perf_stalls;

  wavepool_decode_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
    .clk(clk), .rst(rst), .wf_ready(wf_ready), .decode_stall(decode_stall),
    .wf_release(wf_release), .release_wfid(release_wfid), .wf_flush(wf_flush),
    .arb_valid(arb_valid), .arb_wfid(arb_wfid), .arb_grant(arb_grant),
    .inflight(inflight), .perf_grants(perf_grants), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the DUT outputs should show after the latest edge.
  bit [NUM_WF-1:0] m_inflight;
  int              m_ptr;
  bit              m_valid;
  int              m_wfid;
  bit [NUM_WF-1:0] m_grant;
  bit [31:0]       m_pg;
  bit [31:0]       m_ps;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("arb_valid", 64'(arb_valid), 64'(m_valid));
    chk("arb_wfid",  64'(arb_wfid),  64'(m_wfid));
    chk("arb_grant", 64'(arb_grant), 64'(m_grant));
    chk("inflight",  64'(inflight),  64'(m_inflight));
`ifdef ARB_PERF_CNT_EN
    chk("perf_grants", 64'(perf_grants), 64'(m_pg));
    chk("perf_stalls", 64'(perf_stalls), 64'(m_ps));
`else
    chk("perf_grants", 64'(perf_grants), 64'd0);
    chk("perf_stalls", 64'(perf_stalls), 64'd0);
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied, then compare.
  task automatic step();
    bit [NUM_WF-1:0] elig;
    int w;
    bit g;
    if (rst) begin
      m_inflight = '0; m_ptr = 0; m_valid = 0; m_wfid = 0; m_grant = '0; m_pg = 0; m_ps = 0;
    end else begin
      elig = wf_ready & ~m_inflight & ~wf_flush;
      w = -1;
      for (int k = 0; k < NUM_WF; k++)
        if (w < 0 && elig[(m_ptr + k) % NUM_WF]) w = (m_ptr + k) % NUM_WF;
      g = (w >= 0) && !decode_stall;
      if (decode_stall && elig != '0) m_ps++;
      if (wf_release && int'(release_wfid) < NUM_WF) m_inflight[release_wfid] = 1'b0;
      if (g) m_inflight[w] = 1'b1;
      m_inflight &= ~wf_flush;
      m_valid = g;
      m_grant = '0;
      if (g) begin
        m_grant[w] = 1'b1;
        m_wfid = w;
        m_ptr = (w + 1) % NUM_WF;
        m_pg++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wf_ready = '0; decode_stall = 0; wf_release = 0; release_wfid = '0; wf_flush = '0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    int seq[$];
    int exp_seq[6] = '{3, 7, 39, 3, 7, 39};
    rst = 1;
    idle_inputs();

    // Reset with every wavefront ready: outputs stay clear, then wfid 0, 1, 2 follow.
    wf_ready = '1;
    step(); step();
    chk("reset_valid", 64'(arb_valid), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    rst = 0;
    step();
    chk("first_grant_valid", 64'(arb_valid), 64'd1);
    chk("first_grant_wfid", 64'(arb_wfid), 64'd0);
    step();
    chk("second_grant_wfid", 64'(arb_wfid), 64'd1);
    step();
    chk("third_grant_wfid", 64'(arb_wfid), 64'd2);
    // Mid-operation reset discards the pending grant.
    rst = 1; step();
    chk("midreset_valid", 64'(arb_valid), 64'd0);
    step(); rst = 0;

    // Fairness with immediate release, including wrap from 39 back to 3.
    idle_inputs();
    wf_ready[3] = 1; wf_ready[7] = 1; wf_ready[39] = 1;
    for (int n = 0; n < 12 && seq.size() < 6; n++) begin
      wf_release = m_valid;
      release_wfid = WFID_W'(m_wfid);
      step();
      if (arb_valid) seq.push_back(int'(arb_wfid));
    end
    chk("fair_count", 64'(seq.size()), 64'd6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("fair_seq", 64'(seq[i]), 64'(exp_seq[i]));

    // In-flight blocking and release-to-regrant latency.
    idle_inputs(); do_reset();
    wf_ready[5] = 1;
    step();
    chk("block_first", 64'(arb_wfid), 64'd5);
    step(); step();
    chk("block_held", 64'(arb_valid), 64'd0);
    wf_release = 1; release_wfid = 6'd5;
    step();
    wf_release = 0;
    chk("release_n1", 64'(arb_valid), 64'd0);
    step();
    chk("release_n2_valid", 64'(arb_valid), 64'd1);
    chk("release_n2_wfid", 64'(arb_wfid), 64'd5);

    // Backpressure for four cycles, then grant once the stall drops.
    idle_inputs(); do_reset();
    wf_ready[2] = 1; decode_stall = 1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("stall_valid", 64'(arb_valid), 64'd0);
    end
`ifdef ARB_PERF_CNT_EN
    chk("stall_count", 64'(perf_stalls), 64'd4);
`endif
    decode_stall = 0;
    step();
    chk("unstall_wfid", 64'(arb_wfid), 64'd2);
    chk("unstall_valid", 64'(arb_valid), 64'd1);

    // Flush and release on the same in-flight wavefront.
    idle_inputs(); do_reset();
    wf_ready[9] = 1;
    step();
    chk("flush_setup", 64'(inflight[9]), 64'd1);
    wf_ready = '0; wf_flush[9] = 1; wf_release = 1; release_wfid = 6'd9;
    step();
    chk("flush_release", 64'(inflight[9]), 64'd0);
    // Flush suppresses a grant to the only eligible wavefront.
    idle_inputs();
    wf_ready[4] = 1; wf_flush[4] = 1;
    step();
    chk("flush_suppress", 64'(arb_valid), 64'd0);
    wf_flush = '0;
    step();
    chk("after_flush_wfid", 64'(arb_wfid), 64'd4);

    // Out-of-range release and release of an idle wavefront leave inflight alone.
    wf_ready = '0; wf_release = 1; release_wfid = 6'd45;
    step();
    chk("release_oob", 64'(inflight), 64'(40'h1 << 4));
    release_wfid = 6'd1;
    step();
    chk("release_idle", 64'(inflight), 64'(40'h1 << 4));

    // Randomized traffic against the model.
    idle_inputs(); do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      wf_ready = NUM_WF'({$urandom(), $urandom()});
      decode_stall = ($urandom_range(0, 3) == 0);
      wf_release = $urandom_range(0, 1);
      release_wfid = ($urandom_range(0, 3) == 0) ? WFID_W'($urandom_range(0, 63))
                                                 : WFID_W'(m_wfid);
      wf_flush = '0;
      if ($urandom_range(0, 7) == 0) wf_flush[$urandom_range(0, NUM_WF - 1)] = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
